counter_seq_ctrl: RTL and testbench

//  Sequencing controller for the 4-bit up-counter / hex-display datapath.

---
 rtl/counter_seq_ctrl_if.sv | 23 ++
 rtl/counter_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_ctrl_if.sv
// Button, limit and counter-control bundle between the board-facing logic and counter_seq_ctrl.
// The master side drives the buttons, Limit and the Count feedback; the slave side is the controller.
interface counter_seq_ctrl_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] limit;
    logic [3:0] count;
    logic       cnt_enable;
    logic       cnt_reset_n;
    logic       done;
    logic [2:0] state;

    modport master (
        output start, stop, clear, limit, count,
        input  cnt_enable, cnt_reset_n, done, state
    );

    modport slave (
        input  start, stop, clear, limit, count,
        output cnt_enable, cnt_reset_n, done, state
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Start/Stop/Clear sequencer for the 4-bit counter: synchronised button edges, prescaled enable, terminal stop.
// Optional AUTO_RELOAD_EN: the terminal tick restarts the count through CLEAR instead of parking in DONE.
//
// state | meaning
// IDLE  | waiting for Start or Clear
// CLEAR | one cycle with cnt_reset_n low, prescaler zeroed
// RUN   | prescaler running, enable pulse on each non-terminal tick
// PAUSE | prescaler frozen, waiting for Start or Clear
// DONE  | terminal count reached, Done high
module counter_seq_ctrl #(
    parameter int unsigned PRESCALE   = 50000000,
    parameter int unsigned PRESCALE_W = 26
) (
    input  logic               clk_i,
    input  logic               rst_i,
    counter_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_CLEAR = 3'b001,
        ST_RUN   = 3'b010,
        ST_PAUSE = 3'b011,
        ST_DONE  = 3'b100
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

    // Button vectors are ordered {clear, stop, start}
    logic [2:0] btn_s1_q, btn_s2_q, btn_prev_q;
    logic [2:0] btn_rise;
    logic       start_rise, stop_rise, clear_rise;

    state_t                 state_q, state_d;
    logic [PRESCALE_W-1:0]  presc_q, presc_d;
    logic [3:0]             limit_q, limit_d;
    logic                   reload_q, reload_d;
    logic                   cnt_en_q, cnt_en_d;
    logic                   cnt_rst_n_q, cnt_rst_n_d;
    logic                   done_q, done_d;
    logic                   tick;
    logic                   terminal;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_s1_q   <= 3'b000;
            btn_s2_q   <= 3'b000;
            btn_prev_q <= 3'b000;
        end else begin
            btn_s1_q   <= {bus.clear, bus.stop, bus.start};
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
        end
    end

    assign btn_rise   = btn_s2_q & ~btn_prev_q;
    assign start_rise = btn_rise[0];
    assign stop_rise  = btn_rise[1];
    assign clear_rise = btn_rise[2];

    assign tick     = (presc_q == PRESC_LAST);
    assign terminal = tick && (bus.count == limit_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            limit_q     <= 4'hF;
            reload_q    <= 1'b0;
            cnt_en_q    <= 1'b0;
            cnt_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            limit_q     <= limit_d;
            reload_q    <= reload_d;
            cnt_en_q    <= cnt_en_d;
            cnt_rst_n_q <= cnt_rst_n_d;
            done_q      <= done_d;
        end
    end

    // reload_q records whether the pending CLEAR should continue into RUN
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        cnt_en_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_rise) begin
                    state_d  = ST_CLEAR;
                    reload_d = 1'b0;
                end else if (start_rise) begin
                    state_d  = ST_CLEAR;
                    reload_d = 1'b1;
                    limit_d  = bus.limit;
                end
            end
            ST_CLEAR: begin
                presc_d = '0;
                state_d = reload_q ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (clear_rise) begin
                    state_d  = ST_CLEAR;
                    reload_d = 1'b0;
                end else if (stop_rise) begin
                    state_d = ST_PAUSE;
                end else begin
                    presc_d = tick ? '0 : presc_q + PRESC_ONE;
                    if (terminal) begin
`ifdef AUTO_RELOAD_EN
                        state_d  = ST_CLEAR;
                        reload_d = 1'b1;
                        done_d   = 1'b1;
`else
                        state_d  = ST_DONE;
`endif
                    end else if (tick) begin
                        cnt_en_d = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (clear_rise) begin
                    state_d  = ST_CLEAR;
                    reload_d = 1'b0;
                end else if (start_rise) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (clear_rise) begin
                    state_d  = ST_CLEAR;
                    reload_d = 1'b0;
                end else if (start_rise) begin
                    state_d  = ST_CLEAR;
                    reload_d = 1'b1;
                    limit_d  = bus.limit;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end
        cnt_rst_n_d = (state_d != ST_CLEAR);
    end

    assign bus.cnt_enable  = cnt_en_q;
    assign bus.cnt_reset_n = cnt_rst_n_q;
    assign bus.done        = done_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl with PRESCALE=4 and a behavioural 4-bit counter on the feedback path.
// Each expected state-change event is queued by the stimulus; the monitor pops one per observed State change.
module tb_counter_seq_ctrl;

    localparam int PRESC = 4;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_CLEAR = 3'b001;
    localparam logic [2:0] S_RUN   = 3'b010;
    localparam logic [2:0] S_PAUSE = 3'b011;
    localparam logic [2:0] S_DONE  = 3'b100;

    typedef struct {
        logic [2:0] state;
        logic       done;
        logic       rn;
        int         count;   // -1: not checked
        int         pulses;  // enable pulses since the previous state change, -1: not checked
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cnt_m;
    ev_t        exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    counter_seq_ctrl_if bus();

    counter_seq_ctrl #(.PRESCALE(PRESC), .PRESCALE_W(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)                   cnt_m <= 4'h0;
        else if (!bus.cnt_reset_n) cnt_m <= 4'h0;
        else if (bus.cnt_enable)   cnt_m <= cnt_m + 4'h1;
    end
    assign bus.count = cnt_m;

    function automatic void push(input logic [2:0] s, input logic d, input logic rn,
                                 input int c, input int p);
        ev_t e;
        e.state = s; e.done = d; e.rn = rn; e.count = c; e.pulses = p;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (bus.state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.state !== s) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_state: state %b, expected %b within %0d cycles", bus.state, s, budget);
        end
    endtask

    task automatic wait_enable(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cnt_enable && n < budget);
        if (!bus.cnt_enable) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_enable: no CntEnable within %0d cycles", budget);
        end
    endtask

    task automatic press_start(input int hold);
        bus.start = 1'b1;
        repeat (hold) @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic press_clear(input int hold);
        bus.clear = 1'b1;
        repeat (hold) @(negedge clk);
        bus.clear = 1'b0;
    endtask

    // Monitor: event compare on each State change, plus enable spacing inside a RUN stretch
    initial begin
        logic [2:0] prev_state = S_IDLE;
        int         pulses = 0;
        int         gap = 0;
        bit         gap_valid = 1'b0;
        ev_t        e;
        bit         ok;
        forever begin
            @(negedge clk);
            gap++;
            if (bus.state !== prev_state) begin
                gap_valid = 1'b0;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: state %b count %0d, expected no state change",
                             bus.state, bus.count);
                end else begin
                    e = exp_q.pop_front();
                    ok = (bus.state === e.state) && (bus.done === e.done) &&
                         (bus.cnt_reset_n === e.rn) &&
                         (e.count < 0 || int'(bus.count) == e.count) &&
                         (e.pulses < 0 || pulses == e.pulses);
                    if (!ok) begin
                        miscompares++;
                        $display("FAIL event: got state=%b done=%b rn=%b count=%0d pulses=%0d, expected state=%b done=%b rn=%b count=%0d pulses=%0d",
                                 bus.state, bus.done, bus.cnt_reset_n, bus.count, pulses,
                                 e.state, e.done, e.rn, e.count, e.pulses);
                    end
                end
                pulses = 0;
                prev_state = bus.state;
            end
            if (bus.cnt_enable === 1'b1) begin
                pulses++;
                if (gap_valid) begin
                    vectors++;
                    if (gap != PRESC) begin
                        miscompares++;
                        $display("FAIL enable_gap: got %0d cycles, expected %0d", gap, PRESC);
                    end
                end
                gap = 0;
                gap_valid = 1'b1;
            end
        end
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
        bus.limit = 4'h3;

        // Reset values while reset is held, then CntReset_n releases on the first edge
        @(negedge clk);
        check("rst_state", int'(bus.state), 0);
        check("rst_cnt_enable", int'(bus.cnt_enable), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_cnt_reset_n", int'(bus.cnt_reset_n), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cnt_reset_n", int'(bus.cnt_reset_n), 1);
        check("post_rst_state", int'(bus.state), 0);

`ifdef AUTO_RELOAD_EN
        bus.limit = 4'h2;
        push(S_CLEAR, 1'b0, 1'b0, -1, 0);
        push(S_RUN,   1'b0, 1'b1,  0, 0);
        push(S_CLEAR, 1'b1, 1'b0,  2, 2);
        push(S_RUN,   1'b0, 1'b1,  0, 0);
        push(S_CLEAR, 1'b1, 1'b0,  2, 2);
        push(S_RUN,   1'b0, 1'b1,  0, 0);
        press_start(2);
        for (int w = 0; w < 2; w++) begin
            n = 0;
            while (!bus.done && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!bus.done) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_done: no Done pulse within 100 cycles");
            end
            @(negedge clk);
        end
        wait_state(S_RUN, 20);
        push(S_CLEAR, 1'b0, 1'b0, -1, -1);
        push(S_IDLE,  1'b0, 1'b1,  0, 0);
        press_clear(2);
        wait_state(S_IDLE, 20);
`else
        // Limit 3: three enables, then DONE with the counter parked at 3
        push(S_CLEAR, 1'b0, 1'b0, -1, 0);
        push(S_RUN,   1'b0, 1'b1,  0, 0);
        push(S_DONE,  1'b1, 1'b1,  3, 3);
        press_start(2);
        wait_state(S_DONE, 200);
        repeat (8) @(negedge clk);
        check("done_hold_count", int'(bus.count), 3);

        // Restart from DONE with Limit 5; pause after the first enable, resume with a long Start
        bus.limit = 4'h5;
        push(S_CLEAR, 1'b0, 1'b0, -1, 0);
        push(S_RUN,   1'b0, 1'b1,  0, 0);
        push(S_PAUSE, 1'b0, 1'b1,  1, 1);
        push(S_RUN,   1'b0, 1'b1,  1, 0);
        push(S_DONE,  1'b1, 1'b1,  5, 4);
        press_start(2);
        wait_state(S_RUN, 20);
        wait_enable(50);
        bus.stop = 1'b1;
        repeat (10) @(negedge clk);
        bus.stop = 1'b0;
        check("pause_count", int'(bus.count), 1);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        wait_state(S_RUN, 20);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cnt_enable && n < 20);
        check("resume_phase", n, 2);
        repeat (15) @(negedge clk);
        bus.start = 1'b0;
        wait_state(S_DONE, 200);

        // All three buttons rise together in RUN: Clear wins
        bus.limit = 4'hF;
        push(S_CLEAR, 1'b0, 1'b0, -1, 0);
        push(S_RUN,   1'b0, 1'b1,  0, 0);
        push(S_CLEAR, 1'b0, 1'b0, -1, 2);
        push(S_IDLE,  1'b0, 1'b1,  0, 0);
        press_start(2);
        wait_state(S_RUN, 20);
        wait_enable(50);
        wait_enable(50);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        bus.clear = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
        wait_state(S_IDLE, 20);
        check("simul_count", int'(bus.count), 0);

        // Limit 0 latched; a later Limit change does not move the terminal value
        bus.limit = 4'h0;
        push(S_CLEAR, 1'b0, 1'b0, -1, 0);
        push(S_RUN,   1'b0, 1'b1,  0, 0);
        push(S_DONE,  1'b1, 1'b1,  0, 0);
        press_start(2);
        wait_state(S_RUN, 20);
        bus.limit = 4'h5;
        wait_state(S_DONE, 50);

        // Clear from DONE returns to IDLE
        push(S_CLEAR, 1'b0, 1'b0, -1, 0);
        push(S_IDLE,  1'b0, 1'b1,  0, 0);
        press_clear(2);
        wait_state(S_IDLE, 20);

        // Reset in the middle of a run
        bus.limit = 4'h9;
        push(S_CLEAR, 1'b0, 1'b0, -1, 0);
        push(S_RUN,   1'b0, 1'b1,  0, 0);
        push(S_IDLE,  1'b0, 1'b0,  0, -1);
        press_start(2);
        wait_state(S_RUN, 20);
        wait_enable(50);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst_state", int'(bus.state), 0);
        check("async_rst_cnt_reset_n", int'(bus.cnt_reset_n), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("async_rst_release_rn", int'(bus.cnt_reset_n), 1);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
